ex_hazard_ctrl: RTL and testbench
=================================

Name: ex_hazard_ctrl

Overview:
Pipeline sequencing controller for the RV32I execute stage in the 5-stage core (IF/ID/EX/MEM/WB). It tracks in-flight destination registers in internal EX/MEM/WB shadow slots and produces four kinds of control:
- registered operand-forwarding selects for the EX ALU and branch-compare inputs;
- load-use stall/bubble control;
- branch/jump redirect and flush;
- saturating stall/flush performance counters.

Parameters:
XLEN, 32, width of the performance counters.
REGADDR_W, 5, register address width.

Ports:
clk  in  1  core clock.
rst  in  1  synchronous active-high reset.
id_valid  in  1  ID holds a valid instruction.
id_rs1  in  REGADDR_W  ID source 1 address.
id_rs2  in  REGADDR_W  ID source 2 address.
id_use_rs1  in  1  ID instruction reads rs1.
id_use_rs2  in  1  ID instruction reads rs2.
id_rd  in  REGADDR_W  ID destination address.
id_reg_write  in  1  ID instruction writes rd.
id_mem_read  in  1  ID instruction is a load.
ex_branch  in  1  EX instruction is a conditional branch.
ex_branch_sel  in  1  branch comparator result for EX.
ex_jump  in  2  EX jump type: 00 none, 01 JALR, 10 JAL.
stall_if  out  1  hold PC.
stall_id  out  1  hold IF/ID register.
flush_id  out  1  clear IF/ID register (insert NOP).
bubble_ex  out  1  load a NOP into ID/EX register.
pc_sel  out  1  1 = next PC takes jump_target/branch_target.
fwd_a_sel  out  2  EX rs1 operand source: 00 regfile, 01 MEM-stage result, 10 WB-stage result.
fwd_b_sel  out  2  EX rs2 operand source, same encoding.
stall_count  out  XLEN  cycles with load-use stall asserted.
flush_count  out  XLEN  redirects taken.

Behaviour:
Shadow slots:
- EX, MEM and WB slots each hold {valid, rd, reg_write, mem_read}.
- Each cycle: WB<=MEM; MEM<=EX; EX<=ID fields, or a bubble (valid=0) when bubble_ex=1.
- A slot with rd==0 is treated as reg_write=0.
- All slots are invalid after reset.

Redirect (combinational, same cycle):
- take = EX.valid & ((ex_branch & ex_branch_sel) | (ex_jump != 2'b00)).
- take -> pc_sel=1, flush_id=1, bubble_ex=1.
- ex_jump==2'b11 is treated as no jump.

Load-use (combinational):
- hazard = id_valid & EX.valid & EX.mem_read & EX.reg_write & ((id_use_rs1 & id_rs1==EX.rd) | (id_use_rs2 & id_rs2==EX.rd)).
- hazard & !take -> stall_if=1, stall_id=1, bubble_ex=1.
- Redirect has priority: when take=1, stall_if=stall_id=0, because the stalled ID instruction is being flushed.

Forwarding:
- fwd_a_sel/fwd_b_sel are registered. They are computed from the instruction leaving ID and latched together with the ID->EX advance, so they are valid for the instruction in EX.
- Priority order for rs1 (rs2 identical):
  1. rs unused or rs==0 -> 00.
  2. Match against the EX slot (becomes MEM next cycle) with reg_write and not mem_read -> 01.
  3. Match against the MEM slot (becomes WB next cycle) with reg_write -> 10.
  4. Otherwise -> 00.
- When bubble_ex=1, the next fwd selects are 00.
- A load in MEM with an ID consumer forwards from WB (10); no stall.

Counters:
- stall_count increments on cycles with a stall (hazard & !take).
- flush_count increments on cycles with take.
- Both saturate at all-ones and do not wrap.

Reset:
- While rst=1, all shadow slots are invalid; fwd selects are 00; counters are 0.
- stall_if, stall_id, flush_id, bubble_ex and pc_sel are 0 during rst regardless of inputs.
- Reset mid-stall drops the stall on the next cycle after rst deasserts, because the slots are empty.

Writes from WB to the register file are visible to ID in the same cycle; the regfile is write-through, so no WB->ID forward exists here.

Test Plan:
1. add x5 in EX, ID add reading x5 as rs1 -> next cycle fwd_a_sel=01, fwd_b_sel=00, no stall.
2. lw x7 in EX, ID reads x7 as rs2 -> stall_if=stall_id=bubble_ex=1 for exactly 1 cycle. Then fwd_b_sel=10 in EX, and stall_count increments 0->1.
3. Same rd written by the EX slot (add) and the MEM slot (sub), ID reads it -> fwd select 01 (youngest wins). rd=x0 in the EX slot with ID reading x0 -> 00 and no stall.
4. EX branch with ex_branch_sel=1 coincident with a load-use hazard -> pc_sel=flush_id=bubble_ex=1, stall_if=0, flush_count=1, stall_count unchanged. Same case with ex_branch_sel=0 -> pc_sel=0 and the stall occurs.
5. ex_jump=01 (JALR) and ex_jump=10 (JAL) each -> pc_sel=1. ex_jump=11 -> pc_sel=0.
6. Assert rst during a stall cycle -> all outputs 0 in the rst cycle; counters 0; first cycle after reset shows no stall even if ID still presents a dependency. Preload flush_count to all-ones via 2^XLEN-1 redirects, or force the count -> stays at all-ones on the next redirect.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller for the 5-stage RV32I pipeline: tracks in-flight
// destinations and produces forwarding selects, load-use stalls, redirects and perf counters.
module ex_hazard_ctrl #(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REGADDR_W-1:0] id_rs1,
  input  logic [REGADDR_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REGADDR_W-1:0] id_rd,
  input  logic                 id_reg_write,
  input  logic                 id_mem_read,
  input  logic                 ex_branch,
  input  logic                 ex_branch_sel,
  input  logic [1:0]           ex_jump,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 flush_id,
  output logic                 bubble_ex,
  output logic                 pc_sel,
  output logic [1:0]           fwd_a_sel,
  output logic [1:0]           fwd_b_sel,
  output logic [XLEN-1:0]      stall_count,
  output logic [XLEN-1:0]      flush_count
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Shadow slots. The WB stage needs no slot here: the register file is
  // write-through, so an instruction in WB is already visible to ID.
  logic                 ex_valid, ex_reg_write, ex_mem_read;
  logic [REGADDR_W-1:0] ex_rd;
  logic                 mem_valid, mem_reg_write;
  logic [REGADDR_W-1:0] mem_rd;

  logic       jump_hit, take_raw, hazard, take, stall, bubble;
  logic [1:0] fwd_a_next, fwd_b_next;

  function automatic logic [1:0] fwd_of(input logic [REGADDR_W-1:0] rs, input logic use_rs);
    if (!use_rs || rs == '0)
      return FWD_RF;
    else if (ex_valid && ex_reg_write && !ex_mem_read && rs == ex_rd)
      return FWD_MEM;
    else if (mem_valid && mem_reg_write && rs == mem_rd)
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  always_comb begin
    jump_hit = (ex_jump == 2'b01) || (ex_jump == 2'b10);
    take_raw = ex_valid && ((ex_branch && ex_branch_sel) || jump_hit);
    hazard   = id_valid && ex_valid && ex_mem_read && ex_reg_write &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    // Redirect wins over stall: the instruction that would stall is being flushed.
    take     = !rst && take_raw;
    stall    = !rst && hazard && !take_raw;
    bubble   = take || stall;

    stall_if  = stall;
    stall_id  = stall;
    flush_id  = take;
    pc_sel    = take;
    bubble_ex = bubble;

    fwd_a_next = bubble ? FWD_RF : fwd_of(id_rs1, id_use_rs1);
    fwd_b_next = bubble ? FWD_RF : fwd_of(id_rs2, id_use_rs2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_rd         <= '0;
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_rd        <= '0;
      fwd_a_sel     <= FWD_RF;
      fwd_b_sel     <= FWD_RF;
      stall_count   <= '0;
      flush_count   <= '0;
    end else begin
      mem_valid     <= ex_valid;
      mem_reg_write <= ex_reg_write;
      mem_rd        <= ex_rd;
      if (bubble) begin
        ex_valid     <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_rd        <= '0;
      end else begin
        ex_valid     <= id_valid;
        // Writes to x0 are discarded, so they can never source a forward or a stall.
        ex_reg_write <= id_reg_write && (id_rd != '0);
        ex_mem_read  <= id_mem_read;
        ex_rd        <= id_rd;
      end
      fwd_a_sel <= fwd_a_next;
      fwd_b_sel <= fwd_b_next;
      if (stall && stall_count != '1)
        stall_count <= stall_count + 1'b1;
      if (take && flush_count != '1)
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl: directed scenarios with a forwarding-select
// scoreboard and a bench-side model of the saturating counters.
module tb_ex_hazard_ctrl;

  localparam int XW = 8;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic          ex_branch, ex_branch_sel;
  logic [1:0]    ex_jump;
  logic          stall_if, stall_id, flush_id, bubble_ex, pc_sel;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [XW-1:0] stall_count, flush_count;

  logic [3:0]    exp_q[$];
  logic [3:0]    exp_fwd;
  logic [XW-1:0] exp_stall, exp_flush;
  int            n_checks = 0;
  int            n_fail   = 0;

  ex_hazard_ctrl #(.XLEN(XW), .REGADDR_W(RW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch(ex_branch), .ex_branch_sel(ex_branch_sel), .ex_jump(ex_jump),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
    .bubble_ex(bubble_ex), .pc_sel(pc_sel),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [RW-1:0] rs1, input logic u1,
                          input logic [RW-1:0] rs2, input logic u2,
                          input logic [RW-1:0] rd, input logic wr, input logic mr);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = wr; id_mem_read = mr;
  endtask

  task automatic drain();
    drive_id(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    ex_branch = 1'b0; ex_branch_sel = 1'b0; ex_jump = 2'b00;
    tick(); tick(); tick();
  endtask

  function automatic logic [XW-1:0] sat_inc(input logic [XW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Scenarios
  task automatic test_reset();
    rst = 1'b1;
    drive_id(1'b1, RW'($urandom_range(1, 31)), 1'b1, RW'($urandom_range(1, 31)), 1'b1,
             RW'($urandom_range(1, 31)), 1'b1, 1'b1);
    ex_branch = 1'b1; ex_branch_sel = 1'b1; ex_jump = 2'b10;
    tick(); tick();
    n_checks++;
    if ({stall_if, stall_id, flush_id, bubble_ex, pc_sel} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b, expected 00000", {stall_if, stall_id, flush_id, bubble_ex, pc_sel});
    end
    n_checks++;
    if ({fwd_a_sel, fwd_b_sel, stall_count, flush_count} !== '0) begin
      n_fail++; $display("FAIL reset_regs: got fwd %b/%b cnt %0d/%0d, expected all zero", fwd_a_sel, fwd_b_sel, stall_count, flush_count);
    end
    rst = 1'b0;
    exp_stall = '0; exp_flush = '0;
    drain();
  endtask

  task automatic test_fwd_ex();
    drive_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5
    tick();
    drive_id(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0);   // add x8, x5, x6
    #2;
    n_checks++;
    if ({stall_if, bubble_ex} !== 2'b00) begin
      n_fail++; $display("FAIL fwd_ex_nostall: got stall/bubble %b, expected 00", {stall_if, bubble_ex});
    end
    exp_q.push_back({2'b01, 2'b00});
    tick();
    exp_fwd = exp_q.pop_front();
    n_checks++;
    if ({fwd_a_sel, fwd_b_sel} !== exp_fwd) begin
      n_fail++; $display("FAIL fwd_ex: got %b, expected %b", {fwd_a_sel, fwd_b_sel}, exp_fwd);
    end
    drain();
  endtask

  task automatic test_load_use();
    drive_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);   // lw x7
    tick();
    drive_id(1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);   // reads x7 as rs2
    #2;
    n_checks++;
    if ({stall_if, stall_id, bubble_ex, flush_id, pc_sel} !== 5'b11100) begin
      n_fail++; $display("FAIL load_use_stall: got %b, expected 11100", {stall_if, stall_id, bubble_ex, flush_id, pc_sel});
    end
    exp_stall = sat_inc(exp_stall);
    tick();
    n_checks++;
    if ({stall_if, stall_id, bubble_ex} !== 3'b000) begin
      n_fail++; $display("FAIL load_use_release: got %b, expected 000", {stall_if, stall_id, bubble_ex});
    end
    n_checks++;
    if (stall_count !== exp_stall) begin
      n_fail++; $display("FAIL stall_count: got %0d, expected %0d", stall_count, exp_stall);
    end
    exp_q.push_back({2'b00, 2'b10});
    tick();
    exp_fwd = exp_q.pop_front();
    n_checks++;
    if ({fwd_a_sel, fwd_b_sel} !== exp_fwd) begin
      n_fail++; $display("FAIL load_use_fwd: got %b, expected %b", {fwd_a_sel, fwd_b_sel}, exp_fwd);
    end
    drain();
  endtask

  task automatic test_priority();
    drive_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);   // sub x9 (older)
    tick();
    drive_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd9, 1'b1, 1'b0);   // add x9 (younger)
    tick();
    drive_id(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
    exp_q.push_back({2'b01, 2'b01});
    tick();
    exp_fwd = exp_q.pop_front();
    n_checks++;
    if ({fwd_a_sel, fwd_b_sel} !== exp_fwd) begin
      n_fail++; $display("FAIL fwd_youngest: got %b, expected %b", {fwd_a_sel, fwd_b_sel}, exp_fwd);
    end
    // EX now holds a non-writer; the add x9 sits in MEM.
    drive_id(1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0);
    exp_q.push_back({2'b10, 2'b00});
    tick();
    exp_fwd = exp_q.pop_front();
    n_checks++;
    if ({fwd_a_sel, fwd_b_sel} !== exp_fwd) begin
      n_fail++; $display("FAIL fwd_mem: got %b, expected %b", {fwd_a_sel, fwd_b_sel}, exp_fwd);
    end
    drain();
    drive_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);   // lw x0
    tick();
    drive_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
    #2;
    n_checks++;
    if ({stall_if, bubble_ex} !== 2'b00) begin
      n_fail++; $display("FAIL x0_nostall: got %b, expected 00", {stall_if, bubble_ex});
    end
    exp_q.push_back({2'b00, 2'b00});
    tick();
    exp_fwd = exp_q.pop_front();
    n_checks++;
    if ({fwd_a_sel, fwd_b_sel} !== exp_fwd) begin
      n_fail++; $display("FAIL x0_fwd: got %b, expected %b", {fwd_a_sel, fwd_b_sel}, exp_fwd);
    end
    drain();
  endtask

  task automatic test_branch_vs_stall();
    drive_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);   // lw x7
    tick();
    drive_id(1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);
    ex_branch = 1'b1; ex_branch_sel = 1'b1;
    #2;
    n_checks++;
    if ({pc_sel, flush_id, bubble_ex, stall_if, stall_id} !== 5'b11100) begin
      n_fail++; $display("FAIL branch_priority: got %b, expected 11100", {pc_sel, flush_id, bubble_ex, stall_if, stall_id});
    end
    exp_flush = sat_inc(exp_flush);
    exp_q.push_back({2'b00, 2'b00});
    tick();
    ex_branch = 1'b0; ex_branch_sel = 1'b0;
    drive_id(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    exp_fwd = exp_q.pop_front();
    n_checks++;
    if ({fwd_a_sel, fwd_b_sel} !== exp_fwd) begin
      n_fail++; $display("FAIL branch_bubble_fwd: got %b, expected %b", {fwd_a_sel, fwd_b_sel}, exp_fwd);
    end
    n_checks++;
    if ({flush_count, stall_count} !== {exp_flush, exp_stall}) begin
      n_fail++; $display("FAIL branch_counts: got flush %0d stall %0d, expected %0d %0d", flush_count, stall_count, exp_flush, exp_stall);
    end
    drain();
    drive_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    drive_id(1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);
    ex_branch = 1'b1; ex_branch_sel = 1'b0;
    #2;
    n_checks++;
    if ({pc_sel, flush_id, bubble_ex, stall_if, stall_id} !== 5'b00111) begin
      n_fail++; $display("FAIL branch_not_taken: got %b, expected 00111", {pc_sel, flush_id, bubble_ex, stall_if, stall_id});
    end
    exp_stall = sat_inc(exp_stall);
    tick();
    ex_branch = 1'b0;
    n_checks++;
    if ({flush_count, stall_count} !== {exp_flush, exp_stall}) begin
      n_fail++; $display("FAIL not_taken_counts: got flush %0d stall %0d, expected %0d %0d", flush_count, stall_count, exp_flush, exp_stall);
    end
    drain();
  endtask

  task automatic test_jumps();
    logic exp_take;
    ex_jump = 2'b10;                                             // EX is empty here
    #2;
    n_checks++;
    if (pc_sel !== 1'b0) begin
      n_fail++; $display("FAIL jump_empty_ex: got pc_sel %b, expected 0", pc_sel);
    end
    ex_jump = 2'b00;
    for (int code = 1; code <= 3; code++) begin
      drain();
      drive_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
      tick();
      drive_id(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      ex_jump = 2'(code);
      exp_take = (code != 3);
      #2;
      n_checks++;
      if ({pc_sel, flush_id} !== {exp_take, exp_take}) begin
        n_fail++; $display("FAIL jump_%0d: got pc_sel/flush %b, expected %b", code, {pc_sel, flush_id}, {exp_take, exp_take});
      end
      if (exp_take) exp_flush = sat_inc(exp_flush);
      tick();
      ex_jump = 2'b00;
    end
    n_checks++;
    if (flush_count !== exp_flush) begin
      n_fail++; $display("FAIL jump_flush_count: got %0d, expected %0d", flush_count, exp_flush);
    end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    drive_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    drive_id(1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);
    #2;
    n_checks++;
    if (stall_if !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_stall: got %b, expected 1", stall_if);
    end
    rst = 1'b1;
    #2;
    n_checks++;
    if ({stall_if, stall_id, flush_id, bubble_ex, pc_sel} !== 5'b0) begin
      n_fail++; $display("FAIL reset_in_stall: got %b, expected 00000", {stall_if, stall_id, flush_id, bubble_ex, pc_sel});
    end
    tick();
    exp_stall = '0; exp_flush = '0;
    n_checks++;
    if ({fwd_a_sel, fwd_b_sel, stall_count, flush_count} !== '0) begin
      n_fail++; $display("FAIL reset_clears: got fwd %b/%b cnt %0d/%0d, expected all zero", fwd_a_sel, fwd_b_sel, stall_count, flush_count);
    end
    rst = 1'b0;
    #2;
    n_checks++;
    if ({stall_if, stall_id, bubble_ex} !== 3'b000) begin
      n_fail++; $display("FAIL post_reset_nostall: got %b, expected 000", {stall_if, stall_id, bubble_ex});
    end
    drain();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < (1 << XW); i++) begin
      drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();
      ex_jump = 2'b10;
      #2;
      if (i == (1 << XW) - 1) begin
        n_checks++;
        if (pc_sel !== 1'b1) begin
          n_fail++; $display("FAIL sat_redirect: got pc_sel %b, expected 1", pc_sel);
        end
      end
      exp_flush = sat_inc(exp_flush);
      tick();
      ex_jump = 2'b00;
      if (i == (1 << XW) - 2) begin
        n_checks++;
        if (flush_count !== exp_flush) begin
          n_fail++; $display("FAIL flush_reach_max: got %0d, expected %0d", flush_count, exp_flush);
        end
      end
    end
    n_checks++;
    if (flush_count !== {XW{1'b1}}) begin
      n_fail++; $display("FAIL flush_saturate: got %0d, expected %0d", flush_count, {XW{1'b1}});
    end
    drain();
  endtask

  // Sequence and report
  initial begin
    rst = 1'b1;
    drive_id(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    ex_branch = 1'b0; ex_branch_sel = 1'b0; ex_jump = 2'b00;
    exp_stall = '0; exp_flush = '0;
    #1;
    test_reset();
    test_fwd_ex();
    test_load_use();
    test_priority();
    test_branch_vs_stall();
    test_jumps();
    test_reset_mid_stall();
    test_saturation();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
